// File: rtl/riscv_core_div_ctrl.sv
// Sequencing controller for the M-extension divider: restoring radix-2, one quotient bit per cycle.
// Optional build macro DIV_CTRL_FAST_ZERO_EN skips iteration when |dividend| < |divisor|.
module riscv_core_div_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            i_div_ctrl_clk,
  input  logic            i_div_ctrl_rst_n,
  input  logic            i_div_ctrl_valid,
  output logic            o_div_ctrl_ready,
  input  logic [XLEN-1:0] i_div_ctrl_srcA,
  input  logic [XLEN-1:0] i_div_ctrl_srcB,
  input  logic [1:0]      i_div_ctrl_control,
  input  logic            i_div_ctrl_isword,
  input  logic            i_div_ctrl_flush,
  output logic            o_div_ctrl_valid,
  input  logic            i_div_ctrl_ready,
  output logic [XLEN-1:0] o_div_ctrl_result,
  output logic            o_div_ctrl_busy,
  output logic            o_div_ctrl_dbz
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e          state_q;
  logic            isRem_q, isWord_q, sA_q, sB_q;
  logic            valid_q, dbz_q;
  logic [XLEN-1:0] absB_q, rem_q, quo_q, result_q;
  logic [CW-1:0]   cnt_q;

  logic            isSigned, signA, signB, divZero, ovf, ge;
  logic [XLEN-1:0] opA, opB, absA, absB, minNeg, specialRes;
  logic [XLEN-1:0] shiftR, diff, remNext, qFix, rFix, fixRes;

  function automatic logic [XLEN-1:0] wordFix(input logic [XLEN-1:0] v, input logic w);
    return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
  endfunction

  // Operand conditioning and special-case detection for the accept cycle
  always_comb begin
    isSigned = ~i_div_ctrl_control[0];
    opA = i_div_ctrl_srcA;
    opB = i_div_ctrl_srcB;
    if (i_div_ctrl_isword) begin
      opA = {{HALF{isSigned & i_div_ctrl_srcA[HALF-1]}}, i_div_ctrl_srcA[HALF-1:0]};
      opB = {{HALF{isSigned & i_div_ctrl_srcB[HALF-1]}}, i_div_ctrl_srcB[HALF-1:0]};
    end
    signA   = isSigned & opA[XLEN-1];
    signB   = isSigned & opB[XLEN-1];
    absA    = signA ? -opA : opA;
    absB    = signB ? -opB : opB;
    minNeg  = i_div_ctrl_isword ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                                : {1'b1, {(XLEN-1){1'b0}}};
    divZero = (opB == '0);
    ovf     = isSigned && (opA == minNeg) && (opB == '1);
    specialRes = '1;
    if (divZero)
      specialRes = i_div_ctrl_control[1] ? opA : '1;
    else if (ovf)
      specialRes = i_div_ctrl_control[1] ? '0 : opA;
    specialRes = wordFix(specialRes, i_div_ctrl_isword);
  end

  // Iteration step; the partial remainder's top bit counts as an extra carry so large unsigned divisors work
  always_comb begin
    shiftR  = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    ge      = rem_q[XLEN-1] | (shiftR >= absB_q);
    diff    = shiftR - absB_q;
    remNext = ge ? diff : shiftR;
    qFix    = (sA_q ^ sB_q) ? -quo_q : quo_q;
    rFix    = sA_q ? -rem_q : rem_q;
    fixRes  = wordFix(isRem_q ? rFix : qFix, isWord_q);
  end

  always_ff @(posedge i_div_ctrl_clk or negedge i_div_ctrl_rst_n) begin
    if (!i_div_ctrl_rst_n) begin
      state_q  <= IDLE;
      isRem_q  <= 1'b0;
      isWord_q <= 1'b0;
      sA_q     <= 1'b0;
      sB_q     <= 1'b0;
      valid_q  <= 1'b0;
      dbz_q    <= 1'b0;
      absB_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else if (i_div_ctrl_flush) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_div_ctrl_valid) begin
            isRem_q  <= i_div_ctrl_control[1];
            isWord_q <= i_div_ctrl_isword;
            sA_q     <= signA;
            sB_q     <= signB;
            absB_q   <= absB;
            rem_q    <= '0;
            // W dividends sit in the upper half so the MSB shift-out feeds the remainder
            quo_q    <= i_div_ctrl_isword ? {absA[HALF-1:0], {HALF{1'b0}}} : absA;
            cnt_q    <= i_div_ctrl_isword ? CW'(HALF) : CW'(XLEN);
            dbz_q    <= 1'b0;
            if (divZero || ovf) begin
              state_q  <= DONE;
              valid_q  <= 1'b1;
              result_q <= specialRes;
              dbz_q    <= divZero;
            end
`ifdef DIV_CTRL_FAST_ZERO_EN
            else if (absA < absB) begin
              state_q <= FIX;
              quo_q   <= '0;
              rem_q   <= absA;
            end
`endif
            else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= remNext;
          quo_q <= {quo_q[XLEN-2:0], ge};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1))
            state_q <= FIX;
        end
        FIX: begin
          result_q <= fixRes;
          valid_q  <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          if (i_div_ctrl_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_div_ctrl_ready  = (state_q == IDLE);
  assign o_div_ctrl_busy   = (state_q != IDLE);
  assign o_div_ctrl_valid  = valid_q;
  assign o_div_ctrl_result = result_q;
  assign o_div_ctrl_dbz    = dbz_q;

endmodule

// File: tb/tb_riscv_core_div_ctrl.sv
// Directed testbench for riscv_core_div_ctrl: hand-computed results, latencies, flush, reset and back-pressure.
module tb_riscv_core_div_ctrl;

  localparam int XLEN = 64;
`ifdef DIV_CTRL_FAST_ZERO_EN
  localparam int LAT_SMALL = 2;
`else
  localparam int LAT_SMALL = 66;
`endif

  logic            clk = 1'b0;
  logic            rstN = 1'b0;
  logic            inValid = 1'b0;
  logic            outReady;
  logic [XLEN-1:0] srcA = '0;
  logic [XLEN-1:0] srcB = '0;
  logic [1:0]      control = 2'b00;
  logic            isWord = 1'b0;
  logic            flush = 1'b0;
  logic            outValid;
  logic            consReady = 1'b0;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            dbz;

  int testsRun  = 0;
  int failCount = 0;
  int lat;
  logic [XLEN-1:0] held;

  riscv_core_div_ctrl #(.XLEN(XLEN)) dut (
    .i_div_ctrl_clk     (clk),
    .i_div_ctrl_rst_n   (rstN),
    .i_div_ctrl_valid   (inValid),
    .o_div_ctrl_ready   (outReady),
    .i_div_ctrl_srcA    (srcA),
    .i_div_ctrl_srcB    (srcB),
    .i_div_ctrl_control (control),
    .i_div_ctrl_isword  (isWord),
    .i_div_ctrl_flush   (flush),
    .o_div_ctrl_valid   (outValid),
    .i_div_ctrl_ready   (consReady),
    .o_div_ctrl_result  (result),
    .o_div_ctrl_busy    (busy),
    .o_div_ctrl_dbz     (dbz)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                             input logic [XLEN-1:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Issue one operation and return edges from accept (inclusive) to valid
  task automatic applyStimulus(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic [1:0] c, input logic w, output int latency);
    int n;
    n = 0;
    @(negedge clk);
    while (!outReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready before issue", {63'd0, outReady}, 64'd1);
    srcA = a; srcB = b; control = c; isWord = w; inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    srcA = '0; srcB = '0;
    latency = 1;
    while (!outValid && latency < 200) begin
      @(posedge clk);
      #1;
      latency++;
    end
  endtask

  task automatic releaseResult();
    @(negedge clk);
    consReady = 1'b1;
    @(posedge clk);
    #1;
    consReady = 1'b0;
    checkOutput("valid low after release", {63'd0, outValid}, 64'd0);
  endtask

  task automatic runAndCheck(input string tag, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input logic [1:0] c, input logic w, input logic [XLEN-1:0] expRes,
                             input logic expDbz, input int expLat);
    int l;
    applyStimulus(a, b, c, w, l);
    checkOutput({tag, " result"}, result, expRes);
    checkOutput({tag, " dbz"}, {63'd0, dbz}, {63'd0, expDbz});
    checkOutput({tag, " latency"}, 64'(l), 64'(expLat));
    releaseResult();
  endtask

  initial begin
    #12;
    checkOutput("reset ready", {63'd0, outReady}, 64'd1);
    checkOutput("reset valid", {63'd0, outValid}, 64'd0);
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset dbz", {63'd0, dbz}, 64'd0);
    checkOutput("reset result", result, 64'd0);
    @(negedge clk);
    rstN = 1'b1;

    runAndCheck("DIV -20/3", 64'hFFFFFFFFFFFFFFEC, 64'd3, 2'b00, 1'b0, 64'hFFFFFFFFFFFFFFFA, 1'b0, 66);
    runAndCheck("REM -20/3", 64'hFFFFFFFFFFFFFFEC, 64'd3, 2'b10, 1'b0, 64'hFFFFFFFFFFFFFFFE, 1'b0, 66);
    runAndCheck("DIVU x/0", 64'hFFFFFFFFFFFFFFFF, 64'd0, 2'b01, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1);
    runAndCheck("REMU x/0", 64'hFFFFFFFFFFFFFFFF, 64'd0, 2'b11, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1);
    runAndCheck("REMUW 5/0", 64'hABCD000000000005, 64'd0, 2'b11, 1'b1, 64'h0000000000000005, 1'b1, 1);
    runAndCheck("DIV ovf", 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 2'b00, 1'b0, 64'h8000000000000000, 1'b0, 1);
    runAndCheck("REM ovf", 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 2'b10, 1'b0, 64'h0, 1'b0, 1);
    runAndCheck("DIVW ovf", 64'h0000000080000000, 64'hFFFFFFFFFFFFFFFF, 2'b00, 1'b1, 64'hFFFFFFFF80000000, 1'b0, 1);
    runAndCheck("DIVUW", 64'h12345678FFFFFFFE, 64'd2, 2'b01, 1'b1, 64'h000000007FFFFFFF, 1'b0, 34);
    runAndCheck("REMW -7/2", 64'h00000000FFFFFFF9, 64'd2, 2'b10, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 34);
    runAndCheck("DIVU big divisor", 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001, 2'b01, 1'b0, 64'd1, 1'b0, 66);
    runAndCheck("REMU big divisor", 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001, 2'b11, 1'b0, 64'h7FFFFFFFFFFFFFFE, 1'b0, 66);
    runAndCheck("DIV -3/10", 64'hFFFFFFFFFFFFFFFD, 64'd10, 2'b00, 1'b0, 64'd0, 1'b0, LAT_SMALL);
    runAndCheck("REM -3/10", 64'hFFFFFFFFFFFFFFFD, 64'd10, 2'b10, 1'b0, 64'hFFFFFFFFFFFFFFFD, 1'b0, LAT_SMALL);

    // Flush during CALC
    @(negedge clk);
    srcA = 64'd100; srcB = 64'd7; control = 2'b00; isWord = 1'b0; inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checkOutput("busy after accept", {63'd0, busy}, 64'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush busy", {63'd0, busy}, 64'd0);
    checkOutput("flush ready", {63'd0, outReady}, 64'd1);
    checkOutput("flush valid", {63'd0, outValid}, 64'd0);

    // Request coincident with flush in IDLE is dropped
    @(negedge clk);
    srcA = 64'd100; srcB = 64'd7; inValid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0; flush = 1'b0;
    checkOutput("flush+req busy", {63'd0, busy}, 64'd0);
    runAndCheck("DIV 100/7", 64'd100, 64'd7, 2'b00, 1'b0, 64'd14, 1'b0, 66);

    // Reset mid-operation
    @(negedge clk);
    srcA = 64'd100; srcB = 64'd7; control = 2'b00; inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("midop reset busy", {63'd0, busy}, 64'd0);
    checkOutput("midop reset valid", {63'd0, outValid}, 64'd0);
    @(negedge clk);
    rstN = 1'b1;

    // Back-pressure hold in DONE with an ignored request
    applyStimulus(64'd1000, 64'hFFFFFFFFFFFFFFF6, 2'b00, 1'b0, lat);
    checkOutput("hold latency", 64'(lat), 64'd66);
    checkOutput("hold first result", result, 64'hFFFFFFFFFFFFFF9C);
    held = 64'hFFFFFFFFFFFFFF9C;
    @(negedge clk);
    srcA = 64'd17; srcB = 64'd5; control = 2'b11; inValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold valid", {63'd0, outValid}, 64'd1);
      checkOutput("hold result", result, held);
      checkOutput("hold ready", {63'd0, outReady}, 64'd0);
    end
    @(negedge clk);
    inValid = 1'b0;
    consReady = 1'b1;
    @(posedge clk);
    #1;
    consReady = 1'b0;
    checkOutput("post-hold valid", {63'd0, outValid}, 64'd0);
    checkOutput("post-hold ready", {63'd0, outReady}, 64'd1);
    runAndCheck("REMU 17/5", 64'd17, 64'd5, 2'b11, 1'b0, 64'd2, 1'b0, 66);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
